modulo_counter_n: RTL and testbench
===================================

MODULO_COUNTER_N -- requirements
Module: modulo_counter_n

Interface
REQ-001 Parameter MODULUS, default 60, sets the count range to 0..MODULUS-1; legal range 2..2^WIDTH.
REQ-002 Parameter WIDTH, default 6, sets the width of the count and load value.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pause  input  1  high: hold count (no step); load still honoured.
REQ-006 cnt_en  input  1  cascade enable (carry-in from a lower stage); a step occurs only when cnt_en=1 and pause=0.
REQ-007 up_down  input  1  1 = count up, 0 = count down; sampled on each step edge.
REQ-008 one_shot  input  1  1 = stop at terminal value instead of wrapping.
REQ-009 load  input  1  synchronous load strobe.
REQ-010 load_val  input  WIDTH  value loaded when load=1.
REQ-011 val_bin  output  WIDTH  registered count value.
REQ-012 carry_out  output  1  registered one-cycle wrap/terminal pulse, usable as cnt_en of the next stage.
REQ-013 terminal  output  1  combinational: (up_down=1 and val_bin=MODULUS-1) or (up_down=0 and val_bin=0).
REQ-014 done  output  1  registered sticky one-shot completion flag.
REQ-015 load_err  output  1  registered one-cycle pulse flagging an out-of-range load.

Function
REQ-016 Per-edge priority SHALL be reset > load > step > hold.
REQ-017 Step definition: cnt_en=1, pause=0, load=0, done=0.
REQ-018 Up step: val_bin+1, with MODULUS-1 -> 0 wrap; down step: val_bin-1, with 0 -> MODULUS-1 wrap.
REQ-019 carry_out SHALL be 1 for exactly the cycle after a step taken while terminal=1, and 0 on every other cycle, including hold, load and pause cycles.
REQ-020 Wrap mode (one_shot=0): a step with terminal=1 wraps val_bin and pulses carry_out.
REQ-021 One-shot mode (one_shot=1): a step with terminal=1 leaves val_bin unchanged, pulses carry_out once, and sets done.
REQ-022 While done=1, steps SHALL be ignored; val_bin holds and carry_out stays 0.
REQ-023 done SHALL clear only on load or reset.
REQ-024 Clearing one_shot while done=1 SHALL NOT clear done.
REQ-025 Load with load_val < MODULUS: val_bin=load_val, done=0, carry_out=0, load_err=0.
REQ-026 Load with load_val >= MODULUS: val_bin=0, done=0, and load_err=1 for one cycle.
REQ-027 Load and step asserted on the same edge: load wins and no step occurs.
REQ-028 Changing up_down on any cycle SHALL take effect on the next step, with no glitch on val_bin.
REQ-029 Reaching MODULUS-1 (up) or 0 (down) by a normal step SHALL NOT pulse carry_out; the pulse occurs only when stepping away from terminal.
REQ-030 Counter state SHALL never leave 0..MODULUS-1 by any path other than reset.
REQ-031 Arithmetic SHALL be done at WIDTH+1 bits internally so that MODULUS=2^WIDTH wraps correctly without overflow aliasing.
REQ-032 With MODULUS=60, chaining the carry_out of a seconds stage into the cnt_en of a minutes stage SHALL advance minutes exactly once per 60 seconds steps.

Reset
REQ-033 Reset assertion SHALL immediately force val_bin=0, carry_out=0, done=0 and load_err=0, independent of the clock.
REQ-034 Reset asserted mid-count, including during a carry_out pulse, SHALL abort the pulse.
REQ-035 After reset deassertion, the first step SHALL occur on the first rising edge with step conditions met.

Verification
REQ-036 MODULUS=60, up, cnt_en=1, 61 steps from reset -> val_bin 0..59, then 0; carry_out=1 only in the cycle after the 60th step; val_bin=1 after step 61.
REQ-037 Down, load 0, then 2 steps -> val_bin 59, then 58; carry_out pulses once after the first step.
REQ-038 one_shot=1, up, load 58, then 4 steps -> val_bin 59, 59, 59, 59; carry_out pulses once; done=1 from the second step onward; load 10 -> done=0, val_bin=10.
REQ-039 pause=1 with cnt_en=1 for 5 cycles at val_bin=59 -> no change, no carry_out; pause=0 -> wraps to 0 with carry_out pulse.
REQ-040 Load 63 with MODULUS=60 -> val_bin=0, load_err single-cycle pulse; load and step on the same edge -> loaded value, no increment.
REQ-041 Async reset asserted between edges at val_bin=59 while carry_out is high -> outputs zero before the next edge; two chained instances (60 x 60) over 3600 steps -> minutes stage wraps once and its carry_out pulses once.

Source files
------------

// File: rtl/modulo_counter_n.sv
// Cascadable modulo-MODULUS up/down counter with load, pause, one-shot stop and range-checked load.
// Latency: val_bin/carry_out/done/load_err are registered (one edge); terminal is combinational; no backpressure, steps gated by cnt_en/pause.
module modulo_counter_n #(
  parameter int MODULUS = 60,
  parameter int WIDTH   = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pause,
  input  logic             cnt_en,
  input  logic             up_down,
  input  logic             one_shot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] val_bin,
  output logic             carry_out,
  output logic             terminal,
  output logic             done,
  output logic             load_err
);

  // One extra bit so MODULUS = 2**WIDTH is representable and compares cleanly.
  localparam logic [WIDTH:0] LAST    = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] ONE     = (WIDTH+1)'(1);

  logic [WIDTH:0] cur_ext;
  logic [WIDTH:0] load_ext;
  logic [WIDTH:0] inc_ext;
  logic [WIDTH:0] dec_ext;
  logic [WIDTH:0] step_ext;
  logic           at_top;
  logic           at_bottom;
  logic           load_ok;
  logic           step_ok;
  logic           step;

  always_comb begin
    cur_ext   = {1'b0, val_bin};
    load_ext  = {1'b0, load_val};
    at_top    = (cur_ext == LAST);
    at_bottom = (cur_ext == '0);
    inc_ext   = at_top    ? '0   : cur_ext + ONE;
    dec_ext   = at_bottom ? LAST : cur_ext - ONE;
    step_ext  = up_down ? inc_ext : dec_ext;
    // Guard keeps the state inside 0..MODULUS-1 even if it were ever corrupted.
    step_ok   = (step_ext < MOD_EXT);
    load_ok   = (load_ext < MOD_EXT);
    step      = cnt_en & ~pause & ~done;
    terminal  = up_down ? at_top : at_bottom;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      val_bin   <= '0;
      carry_out <= 1'b0;
      done      <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      carry_out <= 1'b0;
      load_err  <= 1'b0;
      if (load) begin
        val_bin  <= load_ok ? load_val : '0;
        done     <= 1'b0;
        load_err <= ~load_ok;
      end else if (step) begin
        if (terminal) begin
          carry_out <= 1'b1;
          if (one_shot) begin
            done <= 1'b1;
          end else begin
            val_bin <= step_ok ? step_ext[WIDTH-1:0] : '0;
          end
        end else begin
          val_bin <= step_ok ? step_ext[WIDTH-1:0] : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_modulo_counter_n.sv
// Scoreboard bench for modulo_counter_n (MODULUS=60): driver queues expected post-edge state, monitor compares after each edge.
`timescale 1ns/1ps
module tb_modulo_counter_n;

  logic       clock = 1'b0;
  logic       reset;
  logic       pause, cnt_en, up_down, one_shot, load;
  logic [5:0] load_val;
  logic [5:0] val_bin;
  logic       carry_out, terminal, done, load_err;

  logic       sec_en;
  logic [5:0] sec_val, min_val;
  logic       sec_carry, sec_term, sec_done, sec_lerr;
  logic       min_carry, min_term, min_done, min_lerr;

  always #5 clock = ~clock;

  modulo_counter_n #(.MODULUS(60), .WIDTH(6)) dut (
    .clock(clock), .reset(reset), .pause(pause), .cnt_en(cnt_en), .up_down(up_down),
    .one_shot(one_shot), .load(load), .load_val(load_val), .val_bin(val_bin),
    .carry_out(carry_out), .terminal(terminal), .done(done), .load_err(load_err));

  modulo_counter_n #(.MODULUS(60), .WIDTH(6)) u_sec (
    .clock(clock), .reset(reset), .pause(1'b0), .cnt_en(sec_en), .up_down(1'b1),
    .one_shot(1'b0), .load(1'b0), .load_val(6'd0), .val_bin(sec_val),
    .carry_out(sec_carry), .terminal(sec_term), .done(sec_done), .load_err(sec_lerr));

  modulo_counter_n #(.MODULUS(60), .WIDTH(6)) u_min (
    .clock(clock), .reset(reset), .pause(1'b0), .cnt_en(sec_carry), .up_down(1'b1),
    .one_shot(1'b0), .load(1'b0), .load_val(6'd0), .val_bin(min_val),
    .carry_out(min_carry), .terminal(min_term), .done(min_done), .load_err(min_lerr));

  typedef struct {
    logic [5:0] v;
    logic       c;
    logic       d;
    logic       e;
    logic       t;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  function automatic void chk(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endfunction

  // Monitor: compares the registered outputs 2ns after every rising edge.
  always @(posedge clock) begin
    #2;
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      chk({nm, ".val"},   int'(val_bin),   int'(e.v));
      chk({nm, ".carry"}, int'(carry_out), int'(e.c));
      chk({nm, ".done"},  int'(done),      int'(e.d));
      chk({nm, ".lerr"},  int'(load_err),  int'(e.e));
      chk({nm, ".term"},  int'(terminal),  int'(e.t));
    end
  end

  // Chain observer for the seconds/minutes cascade.
  logic       chain_on = 1'b0;
  logic [5:0] prev_min = '0;
  int         min_steps = 0, min_pulses = 0, sec_pulses = 0;
  always @(negedge clock) begin
    if (chain_on) begin
      if (min_val != prev_min) min_steps++;
      if (min_carry) min_pulses++;
      if (sec_carry) sec_pulses++;
    end
    prev_min <= min_val;
  end

  // Called at a falling edge: applies inputs for the next rising edge and queues the expected result.
  task automatic drive(input string nm, input logic p, input logic ce, input logic ud,
                       input logic os, input logic ld, input logic [5:0] lv,
                       input logic [5:0] ev, input logic ec, input logic ed, input logic ee);
    exp_t e;
    pause = p; cnt_en = ce; up_down = ud; one_shot = os; load = ld; load_val = lv;
    e.v = ev; e.c = ec; e.d = ed; e.e = ee;
    e.t = ud ? (ev == 6'd59) : (ev == 6'd0);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clock);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear before the next edge.
  task automatic mid_reset(input string nm);
    cnt_en = 1'b0; load = 1'b0; pause = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk({nm, ".val"},   int'(val_bin),   0);
    chk({nm, ".carry"}, int'(carry_out), 0);
    chk({nm, ".done"},  int'(done),      0);
    chk({nm, ".lerr"},  int'(load_err),  0);
    #1 reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; pause = 0; cnt_en = 0; up_down = 1; one_shot = 0; load = 0; load_val = '0;
    sec_en = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst.val",   int'(val_bin),   0);
    chk("rst.carry", int'(carry_out), 0);
    chk("rst.done",  int'(done),      0);
    chk("rst.lerr",  int'(load_err),  0);
    reset = 1'b0;
    @(negedge clock);

    // 61 up steps from reset: 1..59, 0 (with carry), 1
    for (int i = 1; i <= 61; i++)
      drive($sformatf("up%0d", i), 0, 1, 1, 0, 0, 6'd0, 6'(i % 60), (i == 60), 0, 0);

    // Down from 0 wraps to 59 with carry, then 58
    drive("dn_load0", 0, 0, 0, 0, 1, 6'd0,  6'd0,  0, 0, 0);
    drive("dn_step1", 0, 1, 0, 0, 0, 6'd0,  6'd59, 1, 0, 0);
    drive("dn_step2", 0, 1, 0, 0, 0, 6'd0,  6'd58, 0, 0, 0);

    // Out-of-range and boundary loads, load beats step
    drive("ld63",     0, 0, 1, 0, 1, 6'd63, 6'd0,  0, 0, 1);
    drive("ld63_hold",0, 0, 1, 0, 0, 6'd0,  6'd0,  0, 0, 0);
    drive("ld_step",  0, 1, 1, 0, 1, 6'd25, 6'd25, 0, 0, 0);
    drive("after_ld", 0, 1, 1, 0, 0, 6'd0,  6'd26, 0, 0, 0);
    drive("ld60",     0, 0, 1, 0, 1, 6'd60, 6'd0,  0, 0, 1);
    drive("ld59",     0, 0, 1, 0, 1, 6'd59, 6'd59, 0, 0, 0);

    // Pause at 59 holds without carry, then release wraps
    for (int i = 0; i < 5; i++)
      drive($sformatf("pause%0d", i), 1, 1, 1, 0, 0, 6'd0, 6'd59, 0, 0, 0);
    drive("unpause",  0, 1, 1, 0, 0, 6'd0,  6'd0,  1, 0, 0);
    drive("pause_ld", 1, 1, 1, 0, 1, 6'd5,  6'd5,  0, 0, 0);
    drive("idle",     0, 0, 1, 0, 0, 6'd0,  6'd5,  0, 0, 0);

    // One-shot up: 58 -> 59, then stop at 59 with one carry and sticky done
    drive("os_ld58",  0, 0, 1, 1, 1, 6'd58, 6'd58, 0, 0, 0);
    drive("os_s1",    0, 1, 1, 1, 0, 6'd0,  6'd59, 0, 0, 0);
    drive("os_s2",    0, 1, 1, 1, 0, 6'd0,  6'd59, 1, 1, 0);
    drive("os_s3",    0, 1, 1, 1, 0, 6'd0,  6'd59, 0, 1, 0);
    drive("os_s4",    0, 1, 1, 1, 0, 6'd0,  6'd59, 0, 1, 0);
    drive("os_clr",   0, 1, 1, 0, 0, 6'd0,  6'd59, 0, 1, 0);
    drive("os_dn",    0, 1, 0, 0, 0, 6'd0,  6'd59, 0, 1, 0);
    drive("os_ld10",  0, 0, 1, 1, 1, 6'd10, 6'd10, 0, 0, 0);
    // One-shot down: 1 -> 0, then stop at 0; bad load clears done
    drive("osd_ld1",  0, 0, 0, 1, 1, 6'd1,  6'd1,  0, 0, 0);
    drive("osd_s1",   0, 1, 0, 1, 0, 6'd0,  6'd0,  0, 0, 0);
    drive("osd_s2",   0, 1, 0, 1, 0, 6'd0,  6'd0,  1, 1, 0);
    drive("osd_s3",   0, 1, 0, 1, 0, 6'd0,  6'd0,  0, 1, 0);
    drive("osd_ld63", 0, 0, 0, 1, 1, 6'd63, 6'd0,  0, 0, 1);

    // Direction changes take effect on the next step
    drive("ud_ld30",  0, 0, 1, 0, 1, 6'd30, 6'd30, 0, 0, 0);
    drive("ud_up",    0, 1, 1, 0, 0, 6'd0,  6'd31, 0, 0, 0);
    drive("ud_dn",    0, 1, 0, 0, 0, 6'd0,  6'd30, 0, 0, 0);
    drive("ud_tog",   0, 0, 1, 0, 0, 6'd0,  6'd30, 0, 0, 0);
    drive("ud_up2",   0, 1, 1, 0, 0, 6'd0,  6'd31, 0, 0, 0);

    // Reset during a carry pulse at 59, then first step after reset
    drive("rc_ld0",   0, 0, 0, 0, 1, 6'd0,  6'd0,  0, 0, 0);
    drive("rc_step",  0, 1, 0, 0, 0, 6'd0,  6'd59, 1, 0, 0);
    mid_reset("rst_carry");
    drive("rst_first",0, 1, 1, 0, 0, 6'd0,  6'd1,  0, 0, 0);

    // Reset clears a sticky done
    drive("rd_ld59",  0, 0, 1, 1, 1, 6'd59, 6'd59, 0, 0, 0);
    drive("rd_step",  0, 1, 1, 1, 0, 6'd0,  6'd59, 1, 1, 0);
    mid_reset("rst_done");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
    chk("queue_drained", exp_q.size(), 0);

    // 60 x 60 cascade over 3600 seconds steps
    chain_on = 1'b1;
    sec_en = 1'b1;
    repeat (3600) @(negedge clock);
    sec_en = 1'b0;
    repeat (3) @(negedge clock);
    chain_on = 1'b0;
    chk("chain.sec_pulses", sec_pulses, 60);
    chk("chain.min_steps",  min_steps,  60);
    chk("chain.min_pulses", min_pulses, 1);
    chk("chain.sec_val",    int'(sec_val), 0);
    chk("chain.min_val",    int'(min_val), 0);
    chk("chain.terms",      int'({sec_term, min_term}), 0);
    chk("chain.flags",      int'({sec_done, sec_lerr, min_done, min_lerr}), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
